// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC micro-rotation stages: default widths,
// the per-stage atan(2^-i) increments scaled by 2^14, and the CORDIC gain
// compensation constant used to pre-scale the x input of a rotation chain.
package cordic_pkg;

    localparam int DEF_VALUE_WIDTH   = 14;
    localparam int DEF_ADDRESS_WIDTH = 14;
    localparam int NUM_STAGES        = 13;

    // atan(2^-i) * 2^14 for stage i = 0..12
    localparam logic [DEF_ADDRESS_WIDTH-1:0] ATAN_TABLE [NUM_STAGES] = '{
        14'h3243, 14'h1DAC, 14'h0FAD, 14'h07F5, 14'h03FE, 14'h01FF, 14'h00FF,
        14'h007F, 14'h003F, 14'h001F, 14'h000F, 14'h0007, 14'h0003
    };

    // 0.6073 * 2^14, the inverse of the accumulated chain gain
    localparam logic [DEF_VALUE_WIDTH-1:0] CORDIC_GAIN = 14'h26DD;

endpackage

// File: rtl/cordic_element_if.sv
// One link of a CORDIC chain: the x/y vector and the residual angle z.
// The master side drives a link, the slave side consumes it.
interface cordic_element_if
    import cordic_pkg::*;
#(
    parameter int VALUE_WIDTH   = DEF_VALUE_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
);
    logic [VALUE_WIDTH:0]   x;
    logic [VALUE_WIDTH:0]   y;
    logic [ADDRESS_WIDTH:0] z;

    modport master (output x, y, z);
    modport slave  (input  x, y, z);
endinterface

// File: rtl/cordic_addsub.sv
// Two's complement add/subtract of equal-width operands. With SAT set the
// result clamps to the most positive / most negative value on signed
// overflow; otherwise it wraps modulo 2^WIDTH.
module cordic_addsub #(
    parameter int WIDTH = 15,
    parameter bit SAT   = 1'b0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] res
);
    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] b_ext;
    logic [WIDTH:0] sum;
    logic           ovf;

    // One guard bit exposes signed overflow as a mismatch of the top two bits
    always_comb begin
        a_ext = {a[WIDTH-1], a};
        b_ext = {b[WIDTH-1], b};
        sum   = sub ? (a_ext - b_ext) : (a_ext + b_ext);
        ovf   = sum[WIDTH] ^ sum[WIDTH-1];
        res   = sum[WIDTH-1:0];
        if (SAT && ovf) begin
            res = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
endmodule

// File: rtl/cordic_element.sv
// One pipelined rotation-mode CORDIC micro-rotation stage.
// The sign of the incoming residual angle picks the rotation direction
// (z >= 0 rotates positive); the stage shifts by ORDER and steps the angle
// by e_k. Outputs are registered, one cycle of latency, no enable.
// Build option: define CORDIC_ELEMENT_SAT_EN to saturate x/y on overflow
// instead of wrapping; z always wraps.
module cordic_element
    import cordic_pkg::*;
#(
    parameter int                     VALUE_WIDTH   = DEF_VALUE_WIDTH,
    parameter int                     ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter logic [ADDRESS_WIDTH-1:0] e_k         = 14'h3243,
    parameter int                     ORDER         = 0
) (
    input  logic                   CLK,
    input  logic                   RESET_n,
    input  logic [VALUE_WIDTH:0]   x_k,
    input  logic [VALUE_WIDTH:0]   y_k,
    input  logic [ADDRESS_WIDTH:0] z_k,
    output logic [VALUE_WIDTH:0]   x_k1,
    output logic [VALUE_WIDTH:0]   y_k1,
    output logic [ADDRESS_WIDTH:0] z_k1
);
    localparam int XW = VALUE_WIDTH + 1;
    localparam int ZW = ADDRESS_WIDTH + 1;

`ifdef CORDIC_ELEMENT_SAT_EN
    localparam bit SAT_XY = 1'b1;
`else
    localparam bit SAT_XY = 1'b0;
`endif

    logic          d_neg;
    logic [XW-1:0] x_sh;
    logic [XW-1:0] y_sh;
    logic [XW-1:0] x_nxt;
    logic [XW-1:0] y_nxt;
    logic [ZW-1:0] z_nxt;

    assign d_neg = z_k[ZW-1];
    assign x_sh  = $signed(x_k) >>> ORDER;
    assign y_sh  = $signed(y_k) >>> ORDER;

    // d = +1: x - y', y + x', z - e ; d = -1: the opposite signs
    cordic_addsub #(.WIDTH(XW), .SAT(SAT_XY)) u_add_x (
        .a   (x_k),
        .b   (y_sh),
        .sub (~d_neg),
        .res (x_nxt)
    );

    cordic_addsub #(.WIDTH(XW), .SAT(SAT_XY)) u_add_y (
        .a   (y_k),
        .b   (x_sh),
        .sub (d_neg),
        .res (y_nxt)
    );

    cordic_addsub #(.WIDTH(ZW), .SAT(1'b0)) u_add_z (
        .a   (z_k),
        .b   ({1'b0, e_k}),
        .sub (~d_neg),
        .res (z_nxt)
    );

    // Pipeline register; reset clears the outputs without waiting for CLK
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            x_k1 <= '0;
            y_k1 <= '0;
            z_k1 <= '0;
        end else begin
            x_k1 <= x_nxt;
            y_k1 <= y_nxt;
            z_k1 <= z_nxt;
        end
    end
endmodule

// File: tb/tb_cordic_element.sv
// Directed bench for cordic_element: single stages at ORDER 0/1/2 driven
// from a vector table, reset behaviour, and a 13-stage sin/cos chain.
module tb_cordic_element;
    import cordic_pkg::*;

    logic CLK;
    logic RESET_n;

    int checks   = 0;
    int failures = 0;

    cordic_element_if bus_in ();
    cordic_element_if out0 ();
    cordic_element_if out1 ();
    cordic_element_if out2 ();

    cordic_element #(.ORDER(0), .e_k(14'h3243)) dut0 (
        .CLK(CLK), .RESET_n(RESET_n),
        .x_k(bus_in.x), .y_k(bus_in.y), .z_k(bus_in.z),
        .x_k1(out0.x), .y_k1(out0.y), .z_k1(out0.z)
    );
    cordic_element #(.ORDER(1), .e_k(14'h1DAC)) dut1 (
        .CLK(CLK), .RESET_n(RESET_n),
        .x_k(bus_in.x), .y_k(bus_in.y), .z_k(bus_in.z),
        .x_k1(out1.x), .y_k1(out1.y), .z_k1(out1.z)
    );
    cordic_element #(.ORDER(2), .e_k(14'h0FAD)) dut2 (
        .CLK(CLK), .RESET_n(RESET_n),
        .x_k(bus_in.x), .y_k(bus_in.y), .z_k(bus_in.z),
        .x_k1(out2.x), .y_k1(out2.y), .z_k1(out2.z)
    );

    // 13-stage chain
    logic [14:0] ch_x, ch_y, ch_z;
    wire  [14:0] cx [0:13];
    wire  [14:0] cy [0:13];
    wire  [14:0] cz [0:13];
    assign cx[0] = ch_x;
    assign cy[0] = ch_y;
    assign cz[0] = ch_z;

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_chain
        cordic_element #(.ORDER(i), .e_k(ATAN_TABLE[i])) u_stage (
            .CLK(CLK), .RESET_n(RESET_n),
            .x_k(cx[i]), .y_k(cy[i]), .z_k(cz[i]),
            .x_k1(cx[i+1]), .y_k1(cy[i+1]), .z_k1(cz[i+1])
        );
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        int          sel;
        logic [14:0] x, y, z;
        logic [14:0] ex, ey, ez;
    } vec_t;

`ifdef CORDIC_ELEMENT_SAT_EN
    localparam logic [14:0] Y_POSOVF = 15'h3FFF;
    localparam logic [14:0] Y_NEGOVF = 15'h4000;
`else
    localparam logic [14:0] Y_POSOVF = 15'h7FFE;
    localparam logic [14:0] Y_NEGOVF = 15'h0000;
`endif

    vec_t vecs [7];

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_near(input string name, input int act, input int exp, input int tol);
        checks++;
        if (act < exp - tol || act > exp + tol) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_x0"}, out0.x, 15'h0);
        check({tag, "_y0"}, out0.y, 15'h0);
        check({tag, "_z0"}, out0.z, 15'h0);
        check({tag, "_x2"}, out2.x, 15'h0);
        check({tag, "_z2"}, out2.z, 15'h0);
    endtask

    task automatic drive(input logic [14:0] x, input logic [14:0] y, input logic [14:0] z);
        bus_in.x = x;
        bus_in.y = y;
        bus_in.z = z;
    endtask

    initial begin
        logic [14:0] ax, ay, az;

        vecs[0] = '{"rot0",    0, 15'h26DD, 15'h0000, 15'h3243, 15'h26DD, 15'h26DD, 15'h0000};
        vecs[1] = '{"zzero",   1, 15'h26DD, 15'h26DD, 15'h0000, 15'h136F, 15'h3A4B, 15'h6254};
        vecs[2] = '{"zneg",    2, 15'h136F, 15'h3A4B, 15'h6254, 15'h2201, 15'h3570, 15'h7201};
        vecs[3] = '{"posovf",  0, 15'h3FFF, 15'h3FFF, 15'h0000, 15'h0000, Y_POSOVF, 15'h4DBD};
        vecs[4] = '{"negovf",  0, 15'h4000, 15'h4000, 15'h0000, 15'h0000, Y_NEGOVF, 15'h4DBD};
        vecs[5] = '{"zwrap",   0, 15'h0100, 15'h0200, 15'h7FFF, 15'h0300, 15'h0100, 15'h3242};
        vecs[6] = '{"floor",   2, 15'h7FFF, 15'h7FFD, 15'h0000, 15'h0000, 15'h7FFC, 15'h7053};

        // Reset held with live inputs: outputs stay zero at and between edges
        RESET_n = 1'b0;
        drive(15'h26DD, 15'h0000, 15'h3243);
        ch_x = 15'h0000; ch_y = 15'h0000; ch_z = 15'h0000;
        #2;
        check_all_zero("rst_init");
        repeat (2) begin
            @(posedge CLK); #1;
            check_all_zero("rst_edge");
            @(negedge CLK);
            check_all_zero("rst_mid");
        end
        RESET_n = 1'b1;

        // Table vectors
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].x, vecs[i].y, vecs[i].z);
            @(posedge CLK); #1;
            case (vecs[i].sel)
                0:       begin ax = out0.x; ay = out0.y; az = out0.z; end
                1:       begin ax = out1.x; ay = out1.y; az = out1.z; end
                default: begin ax = out2.x; ay = out2.y; az = out2.z; end
            endcase
            check({vecs[i].name, "_x"}, ax, vecs[i].ex);
            check({vecs[i].name, "_y"}, ay, vecs[i].ey);
            check({vecs[i].name, "_z"}, az, vecs[i].ez);
        end

        // Mid-stream reset: clears immediately, first result one edge after release
        drive(15'h26DD, 15'h0000, 15'h3243);
        @(posedge CLK); #1;
        check("pre_rst_y", out0.y, 15'h26DD);
        #2;
        RESET_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge CLK); #1;
        check_all_zero("rst_hold");
        @(negedge CLK);
        RESET_n = 1'b1;
        #1;
        check("rel_noedge_y", out0.y, 15'h0000);
        @(posedge CLK); #1;
        check("rel_x", out0.x, 15'h26DD);
        check("rel_y", out0.y, 15'h26DD);
        check("rel_z", out0.z, 15'h0000);

        // 13-stage chain: 45 degrees with gain-compensated x
        ch_x = 15'h26DD; ch_y = 15'h0000; ch_z = 15'h3243;
        repeat (NUM_STAGES + 1) @(posedge CLK);
        #1;
        check_near("chain_cos", int'($signed(cx[13])), 32'sh2D41, 8);
        check_near("chain_sin", int'($signed(cy[13])), 32'sh2D41, 8);
        check_near("chain_z",   int'($signed(cz[13])), 0, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
